// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, reset PC, the halt opcode and the
// fetch->decode entry type that both fetch_stage and decode consume.
package cpu_pkg;

   localparam int unsigned CPU_DATA_W = 8;
   localparam int unsigned CPU_ADDR_W = 8;

   localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = 8'h00;
   localparam logic [CPU_DATA_W-1:0] HALT_OPCODE  = 8'hFF;

   typedef struct packed {
      logic [CPU_DATA_W-1:0] instr;
      logic [CPU_ADDR_W-1:0] pc;
   } fetch_entry_t;

   function automatic logic is_halt_opcode(input logic [CPU_DATA_W-1:0] instr);
      return (instr == HALT_OPCODE);
   endfunction

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO of fetch_entry_t with push/pop/flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buf
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PW   = $clog2(DEPTH),
   localparam int unsigned CW   = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  fetch_entry_t  entry_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output fetch_entry_t  head_o,
   output logic          valid_o,
   output logic [CW-1:0] count_o
);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_s;
   logic          push_s;
   logic          pop_s;

   assign full_s  = (count_q == CW'(DEPTH));
   assign valid_o = (count_q != '0);
   assign push_s  = push_i && !full_s && !flush_i;
   assign pop_s   = pop_i && valid_o && !flush_i;
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Pointer and occupancy next state; flush wins over push and pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         count_d = count_q + CW'(push_s) - CW'(pop_s);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage, cleared on reset so the head reads zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
      end else if (push_s) begin
         mem_q[wr_ptr_q] <= entry_i;
      end else begin
         mem_q <= mem_q;
      end
   end

   fetch_buf_chk #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_chk (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_i),
      .pop_i   (pop_i),
      .flush_i (flush_i),
      .full_i  (full_s),
      .count_i (count_q)
   );

endmodule

// File: rtl/fetch_buf_chk.sv
// Protocol checker for fetch_buf: overflow, underflow and count range.
// Synthesis ignores it; simulation flags any credit leak in the fetch stage.
module fetch_buf_chk #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CW    = 2
) (
   input logic          clk,
   input logic          rst_n,
   input logic          push_i,
   input logic          pop_i,
   input logic          flush_i,
   input logic          full_i,
   input logic [CW-1:0] count_i
);

   // A push into a full buffer means the issue credit accounting is broken.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push_i && full_i && !flush_i));

   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(pop_i && (count_i == '0) && !flush_i));

   a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
      (count_i <= CW'(DEPTH)));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle imem and feeds decode
// over valid/ready. Define FETCH_HALT_EN to stop fetch after an all-ones opcode.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int unsigned       DATA_W    = CPU_DATA_W,
   parameter int unsigned       ADDR_W    = CPU_ADDR_W,
   parameter int unsigned       BUF_DEPTH = 2,
   parameter logic [ADDR_W-1:0] RESET_PC  = CPU_RESET_PC
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              halted
);

   localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              inflight_q, inflight_d;
   logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
   logic              halted_s;
   logic              issue_s;
   logic              push_s;
   logic              pop_s;
   logic              buf_valid_s;
   logic [CW-1:0]     count_s;
   logic [CW:0]       credit_s;
   fetch_entry_t      push_entry_s;
   fetch_entry_t      head_s;

   // A same-cycle pop frees a slot, which is what sustains one fetch per cycle.
   assign pop_s    = buf_valid_s && out_ready;
   assign credit_s = {1'b0, count_s} + (CW+1)'(inflight_q) - (CW+1)'(pop_s);
   assign issue_s  = rst_n && !redirect_valid && !halted_s
                     && (credit_s < (CW+1)'(BUF_DEPTH));
   assign push_s   = inflight_q && !redirect_valid && !halted_s;

   assign push_entry_s.instr = imem_rdata;
   assign push_entry_s.pc    = inflight_pc_q;

   // PC and in-flight tracking; a redirect overrides the sequential PC.
   always_comb begin
      pc_d          = pc_q;
      inflight_pc_d = inflight_pc_q;
      inflight_d    = issue_s;
      if (redirect_valid) begin
         pc_d = redirect_pc;
      end else if (issue_s) begin
         pc_d = pc_q + ADDR_W'(1);
      end else begin
         pc_d = pc_q;
      end
      if (issue_s) begin
         inflight_pc_d = pc_q;
      end else begin
         inflight_pc_d = inflight_pc_q;
      end
   end

   // PC and in-flight registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

`ifdef FETCH_HALT_EN
   logic halted_q, halted_d;

   // Halt latches once the halt opcode is pushed; only a redirect releases it.
   always_comb begin
      halted_d = halted_q;
      if (redirect_valid) begin
         halted_d = 1'b0;
      end else if (push_s && is_halt_opcode(imem_rdata)) begin
         halted_d = 1'b1;
      end else begin
         halted_d = halted_q;
      end
   end

   // Halt flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= halted_d;
      end
   end

   assign halted_s = halted_q;
`else
   assign halted_s = 1'b0;
`endif

   fetch_buf #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_s),
      .entry_i (push_entry_s),
      .pop_i   (pop_s),
      .flush_i (redirect_valid),
      .head_o  (head_s),
      .valid_o (buf_valid_s),
      .count_o (count_s)
   );

   assign imem_req  = issue_s;
   assign imem_addr = pc_q;
   assign out_valid = buf_valid_s;
   assign out_instr = head_s.instr;
   assign out_pc    = head_s.pc;
   assign halted    = halted_s;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, backpressure, redirect, PC wrap,
// async reset and the optional halt behaviour (FETCH_HALT_EN).
module tb_fetch_stage;

   logic       clk;
   logic       rst_n;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic [7:0] imem_rdata;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_instr;
   logic [7:0] out_pc;
   logic       redirect_valid;
   logic [7:0] redirect_pc;
   logic       halted;
   logic       ff_at3;
   int         vectors;
   int         errors;

   fetch_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: one-cycle latency, contents addr+0x10 (0xFF at 3 on demand).
   always @(posedge clk) begin
      if (imem_req) begin
         imem_rdata <= (ff_at3 && imem_addr == 8'h03) ? 8'hFF : imem_addr + 8'h10;
      end else begin
         imem_rdata <= 8'h00;
      end
   end

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_req(input string tag, input logic req, input logic [7:0] addr);
      chk1({tag, ".req"}, imem_req, req);
      if (req) chk8({tag, ".addr"}, imem_addr, addr);
   endtask

   task automatic chk_out(input string tag, input logic [7:0] pc, input logic [7:0] instr);
      chk1({tag, ".valid"}, out_valid, 1'b1);
      chk8({tag, ".pc"}, out_pc, pc);
      chk8({tag, ".instr"}, out_instr, instr);
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      vectors = 0;
      errors = 0;
      rst_n = 1'b0;
      out_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 8'h00;
      ff_at3 = 1'b0;

      // Reset values
      cyc(); settle();
      chk1("rst.req", imem_req, 1'b0);
      chk1("rst.valid", out_valid, 1'b0);
      chk8("rst.instr", out_instr, 8'h00);
      chk8("rst.pc", out_pc, 8'h00);
      chk1("rst.halted", halted, 1'b0);

      // Streaming with out_ready=1: one instruction per cycle from cycle 2
      cyc(); rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         settle();
         chk_req("stream", 1'b1, 8'(k));
         if (k >= 2) chk_out("stream", 8'(k - 2), 8'(k + 14));
         else chk1("stream.valid", out_valid, 1'b0);
         cyc();
      end

      // Redirect to 0xFE then PC wrap through 0xFF -> 0x00
      redirect_valid = 1'b1; redirect_pc = 8'hFE; settle();
      chk1("wrap.redir_req", imem_req, 1'b0);
      cyc(); redirect_valid = 1'b0; settle();
      chk1("wrap.flush_valid", out_valid, 1'b0);
      chk_req("wrap.c1", 1'b1, 8'hFE);
      cyc(); settle();
      chk_req("wrap.c2", 1'b1, 8'hFF);
      cyc(); settle();
      chk_req("wrap.c3", 1'b1, 8'h00);
      chk_out("wrap.c3", 8'hFE, 8'h0E);
      cyc(); settle();
      chk_req("wrap.c4", 1'b1, 8'h01);
      chk_out("wrap.c4", 8'hFF, 8'h0F);
      cyc(); settle();
      chk_out("wrap.c5", 8'h00, 8'h10);

      // Fill the buffer, then async reset mid-stream
      cyc(); out_ready = 1'b0; settle();
      chk_out("fill.c1", 8'h01, 8'h11);
      chk1("fill.c1.req", imem_req, 1'b0);
      cyc(); settle();
      chk_out("fill.c2", 8'h01, 8'h11);
      cyc(); rst_n = 1'b0; settle();
      chk1("arst.valid", out_valid, 1'b0);
      chk8("arst.instr", out_instr, 8'h00);
      chk1("arst.req", imem_req, 1'b0);

      // Restart at RESET_PC with out_ready=0: exactly two requests, head stable
      cyc(); rst_n = 1'b1; settle();
      chk_req("full.A", 1'b1, 8'h00);
      chk1("full.A.valid", out_valid, 1'b0);
      cyc(); settle();
      chk_req("full.B", 1'b1, 8'h01);
      chk1("full.B.valid", out_valid, 1'b0);
      for (int k = 0; k < 4; k++) begin
         cyc(); settle();
         chk1("full.stall.req", imem_req, 1'b0);
         chk_out("full.stall", 8'h00, 8'h10);
      end

      // Release: in-order drain with no gaps after refill
      cyc(); out_ready = 1'b1; settle();
      chk_out("drain.G", 8'h00, 8'h10);
      chk_req("drain.G", 1'b1, 8'h02);
      cyc(); settle();
      chk_out("drain.H", 8'h01, 8'h11);
      chk_req("drain.H", 1'b1, 8'h03);
      cyc(); settle();
      chk_out("drain.I", 8'h02, 8'h12);
      cyc(); settle();
      chk_out("drain.J", 8'h03, 8'h13);

      // Redirect to 0x40 with one entry buffered and one response arriving
      cyc(); out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h40; settle();
      chk_out("redir.K", 8'h04, 8'h14);
      chk1("redir.K.req", imem_req, 1'b0);
      cyc(); redirect_valid = 1'b0; settle();
      chk1("redir.M.valid", out_valid, 1'b0);
      chk_req("redir.M", 1'b1, 8'h40);
      cyc(); settle();
      chk1("redir.N.valid", out_valid, 1'b0);
      chk_req("redir.N", 1'b1, 8'h41);
      cyc(); settle();
      chk_out("redir.O", 8'h40, 8'h50);
      chk1("redir.O.req", imem_req, 1'b0);
      cyc(); out_ready = 1'b1; settle();
      chk_out("redir.P", 8'h40, 8'h50);
      chk_req("redir.P", 1'b1, 8'h42);
      cyc(); settle();
      chk_out("redir.Q", 8'h41, 8'h51);

      // All-ones opcode at address 3
      cyc(); rst_n = 1'b0; ff_at3 = 1'b1; settle();
      cyc(); rst_n = 1'b1; settle();
      chk_req("halt.A", 1'b1, 8'h00);
      cyc(); cyc(); cyc(); settle();
      chk_out("halt.D", 8'h01, 8'h11);
      chk_req("halt.D", 1'b1, 8'h03);
      cyc(); settle();
      chk_out("halt.E", 8'h02, 8'h12);
      chk_req("halt.E", 1'b1, 8'h04);
      chk1("halt.E.halted", halted, 1'b0);
      cyc(); settle();
      chk_out("halt.F", 8'h03, 8'hFF);
`ifdef FETCH_HALT_EN
      chk1("halt.F.halted", halted, 1'b1);
      chk1("halt.F.req", imem_req, 1'b0);
      cyc(); settle();
      chk1("halt.G.valid", out_valid, 1'b0);
      chk1("halt.G.req", imem_req, 1'b0);
      chk1("halt.G.halted", halted, 1'b1);
`else
      chk1("halt.F.halted", halted, 1'b0);
      chk_req("halt.F", 1'b1, 8'h05);
      cyc(); settle();
      chk_out("halt.G", 8'h04, 8'h14);
      chk1("halt.G.halted", halted, 1'b0);
`endif
      cyc(); redirect_valid = 1'b1; redirect_pc = 8'h20; settle();
      chk1("halt.H.req", imem_req, 1'b0);
      cyc(); redirect_valid = 1'b0; settle();
      chk1("halt.I.halted", halted, 1'b0);
      chk_req("halt.I", 1'b1, 8'h20);
      cyc(); settle();
      chk_req("halt.J", 1'b1, 8'h21);
      cyc(); settle();
      chk_out("halt.K", 8'h20, 8'h30);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
